// File: rtl/channel_loader.sv
// channel_loader: packs a valid/ready stream of channel LLRs into P-wide storage words
// and hands the frame to the decoder. Optional clamping with CHANNEL_LOADER_SAT_EN.
module channel_loader #(
  parameter int N    = 1024,
  parameter int P    = 128,
  parameter int Q    = 6,
  parameter int B    = 16,
  parameter int IN_Q = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [B*IN_Q-1:0] llr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              dec_done,
  output logic [P*Q-1:0]    W_channel,
  output logic [4:0]        channel_count,
  output logic              channel_ready,
  output logic              channel,
  output logic [1:0]        state_dbg
);

  localparam int BEATS = P / B;
  localparam int WORDS = N / P;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOAD   = 2'd1,
    DRAIN  = 2'd2,
    DECODE = 2'd3
  } state_t;

  state_t                  state, state_next;
  logic [BW-1:0]           beat_cnt;
  logic [4:0]              word_cnt;
  logic [P*Q-1:0]          stage;
  logic [P*Q-1:0]          word_next;
  logic [B*Q-1:0]          beat_q;
  logic signed [IN_Q-1:0]  llr;
  logic                    accept;
  logic                    last_beat;
  logic                    last_word;

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; the source
  // holds llr_in stable while in_valid is high and in_ready is low.
  assign accept    = in_valid && in_ready;
  assign last_beat = (beat_cnt == BW'(BEATS - 1));
  assign last_word = (word_cnt == 5'(WORDS - 1));
  assign state_dbg = state;

`ifdef CHANNEL_LOADER_SAT_EN
  localparam logic signed [IN_Q-1:0] SAT_MAX = IN_Q'((1 << (Q - 1)) - 1);
  localparam logic signed [IN_Q-1:0] SAT_MIN = -SAT_MAX;
`else
  logic unused_hi;
`endif

  always_comb begin
    beat_q = '0;
    llr    = '0;
`ifndef CHANNEL_LOADER_SAT_EN
    unused_hi = 1'b0;
`endif
    for (int i = 0; i < B; i++) begin
      llr = llr_in[i*IN_Q +: IN_Q];
`ifdef CHANNEL_LOADER_SAT_EN
      if (llr > SAT_MAX)      beat_q[i*Q +: Q] = SAT_MAX[Q-1:0];
      else if (llr < SAT_MIN) beat_q[i*Q +: Q] = SAT_MIN[Q-1:0];
      else                    beat_q[i*Q +: Q] = llr[Q-1:0];
`else
      // Plain truncation: the sign-extension bits above Q are dropped.
      beat_q[i*Q +: Q] = llr[Q-1:0];
      unused_hi = unused_hi ^ (^(llr >>> Q));
`endif
    end
  end

  // The completing beat is merged here so W_channel is loaded on the same edge.
  always_comb begin
    word_next = stage;
    word_next[int'(beat_cnt)*(B*Q) +: B*Q] = beat_q;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (last_beat && last_word) ? DRAIN : LOAD;
      LOAD:    if (accept && last_beat && last_word) state_next = DRAIN;
      DRAIN:   state_next = DECODE;
      DECODE:  if (dec_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      in_ready      <= 1'b1;
      channel       <= 1'b0;
      channel_ready <= 1'b0;
      channel_count <= '0;
      W_channel     <= '0;
      stage         <= '0;
      beat_cnt      <= '0;
      word_cnt      <= '0;
    end else begin
      state         <= state_next;
      in_ready      <= (state_next == IDLE) || (state_next == LOAD);
      channel       <= (state_next == DECODE);
      channel_ready <= 1'b0;
      if (accept) begin
        stage <= word_next;
        if (last_beat) begin
          beat_cnt      <= '0;
          word_cnt      <= last_word ? 5'd0 : word_cnt + 5'd1;
          W_channel     <= word_next;
          channel_count <= word_cnt;
          channel_ready <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + BW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_channel_loader.sv
// Directed bench for channel_loader: stimulus tables, frame sequences and a word scoreboard.
module tb_channel_loader;

  localparam int N = 1024, P = 128, Q = 6, B = 16, IN_Q = 8;
  localparam int BEATS = P / B;
  localparam int WORDS = N / P;
  localparam int NB    = N / B;
  localparam int EW    = P*Q + 5;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [B*IN_Q-1:0] llr_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic              dec_done = 1'b0;
  logic [P*Q-1:0]    W_channel;
  logic [4:0]        channel_count;
  logic              channel_ready;
  logic              channel;
  logic [1:0]        state_dbg;

  channel_loader #(.N(N), .P(P), .Q(Q), .B(B), .IN_Q(IN_Q)) dut (
    .clk(clk), .rst(rst), .llr_in(llr_in), .in_valid(in_valid), .in_ready(in_ready),
    .dec_done(dec_done), .W_channel(W_channel), .channel_count(channel_count),
    .channel_ready(channel_ready), .channel(channel), .state_dbg(state_dbg)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int              errors = 0;
  int              checks = 0;
  int              cycle = 0;
  int              tb_beats = 0;
  logic            strobe_exp = 1'b0;
  logic [EW-1:0]   exp_q[$];
  logic [EW-1:0]   exp_w;
  int              strobe_t[$];
  logic [P*Q-1:0]  word0_cap = '0;
  logic [B*IN_Q-1:0] frame [NB];

  typedef struct {
    logic [7:0] din;
    logic [5:0] sat;
    logic [5:0] trunc;
  } vec_t;
  vec_t vt [B];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  always @(posedge clk) begin
    cycle++;
    strobe_exp = 1'b0;
    if (rst) tb_beats = 0;
    else if (in_valid && in_ready) begin
      if (tb_beats % BEATS == BEATS - 1) strobe_exp = 1'b1;
      tb_beats = (tb_beats + 1) % NB;
    end
  end

  always @(negedge clk) begin
    if (channel_ready || strobe_exp) begin
      checks++;
      if (channel_ready !== strobe_exp) begin
        errors++;
        $display("FAIL strobe: channel_ready=%0b expected %0b (cycle %0d)", channel_ready, strobe_exp, cycle);
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL strobe_extra: strobe with no expected word (cycle %0d)", cycle);
      end else begin
        exp_w = exp_q.pop_front();
        if ({channel_count, W_channel} !== exp_w || channel !== 1'b0) begin
          errors++;
          $display("FAIL word: got cnt=%0d ch=%0b w=%h expected cnt=%0d ch=0 w=%h",
                   channel_count, channel, W_channel, exp_w[EW-1 -: 5], exp_w[P*Q-1:0]);
        end
        strobe_t.push_back(cycle);
        if (channel_count == 5'd0) word0_cap = W_channel;
      end
    end
  end

  // ---------------- model ----------------
  function automatic logic [5:0] tb_conv(input logic [7:0] x);
`ifdef CHANNEL_LOADER_SAT_EN
    if ($signed(x) > 8'sd31) return 6'h1F;
    if ($signed(x) < -8'sd31) return 6'h21;
`endif
    return x[5:0];
  endfunction

  task automatic push_expected(input int nbeats);
    logic [P*Q-1:0] w;
    logic [7:0]     v;
    for (int wi = 0; wi < nbeats / BEATS; wi++) begin
      w = '0;
      for (int j = 0; j < P; j++) begin
        v = frame[wi*BEATS + j/B][(j%B)*IN_Q +: IN_Q];
        w[j*Q +: Q] = tb_conv(v);
      end
      exp_q.push_back({5'(wi), w});
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [B*IN_Q-1:0] d, input int gap);
    int t;
    repeat (gap) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    @(negedge clk);
    in_valid = 1'b1;
    llr_in   = d;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready=0 expected 1 (cycle %0d)", cycle);
    end
    @(posedge clk);
  endtask

  task automatic load_frame(input int nbeats, input int max_gap);
    push_expected(nbeats);
    for (int k = 0; k < nbeats; k++)
      send_beat(frame[k], (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic finish_frame();
    @(negedge clk);
    in_valid = 1'b0;
    chk("drain_channel", 64'(channel), 64'd0);
    chk("drain_in_ready", 64'(in_ready), 64'd0);
    chk("drain_state", 64'(state_dbg), 64'd2);
    @(negedge clk);
    chk("decode_channel", 64'(channel), 64'd1);
    chk("decode_in_ready", 64'(in_ready), 64'd0);
    chk("decode_state", 64'(state_dbg), 64'd3);
    chk("words_left", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic decode_exit();
    @(negedge clk);
    in_valid = 1'b1;
    llr_in   = {B{8'h11}};
    repeat (4) begin
      @(negedge clk);
      chk("hold_in_ready", 64'(in_ready), 64'd0);
      chk("hold_channel", 64'(channel), 64'd1);
    end
    dec_done = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    dec_done = 1'b0;
    chk("exit_channel", 64'(channel), 64'd0);
    chk("exit_in_ready", 64'(in_ready), 64'd1);
    chk("exit_state", 64'(state_dbg), 64'd0);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    chk({tag, "_channel"}, 64'(channel), 64'd0);
    chk({tag, "_channel_ready"}, 64'(channel_ready), 64'd0);
    chk({tag, "_channel_count"}, 64'(channel_count), 64'd0);
    checks++;
    if (W_channel !== '0) begin
      errors++;
      $display("FAIL %s_W_channel: got %h expected 0", tag, W_channel);
    end
    chk({tag, "_state"}, 64'(state_dbg), 64'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    vt[0]  = '{8'h64, 6'h1F, 6'h24};  // +100
    vt[1]  = '{8'h9C, 6'h21, 6'h1C};  // -100
    vt[2]  = '{8'hE0, 6'h21, 6'h20};  // -32
    vt[3]  = '{8'h1F, 6'h1F, 6'h1F};  // +31
    vt[4]  = '{8'h00, 6'h00, 6'h00};
    vt[5]  = '{8'hFF, 6'h3F, 6'h3F};  // -1
    vt[6]  = '{8'h20, 6'h1F, 6'h20};  // +32
    vt[7]  = '{8'hE1, 6'h21, 6'h21};  // -31
    vt[8]  = '{8'h7F, 6'h1F, 6'h3F};  // +127
    vt[9]  = '{8'h80, 6'h21, 6'h00};  // -128
    vt[10] = '{8'h05, 6'h05, 6'h05};
    vt[11] = '{8'hFB, 6'h3B, 6'h3B};  // -5
    vt[12] = '{8'h21, 6'h1F, 6'h21};  // +33
    vt[13] = '{8'hDF, 6'h21, 6'h1F};  // -33
    vt[14] = '{8'h40, 6'h1F, 6'h00};  // +64
    vt[15] = '{8'h0F, 6'h0F, 6'h0F};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_values("reset");
    rst = 1'b0;

    // Frame A: conversion table in beat 0, ramp elsewhere, full rate.
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < B; i++)
        frame[k][i*IN_Q +: IN_Q] = 8'(((k % BEATS) * B + i) % 32);
    for (int i = 0; i < B; i++) frame[0][i*IN_Q +: IN_Q] = vt[i].din;
    load_frame(NB, 0);
    finish_frame();
    for (int i = 0; i < B; i++) begin
`ifdef CHANNEL_LOADER_SAT_EN
      chk($sformatf("conv_%0d", i), 64'(word0_cap[i*Q +: Q]), 64'(vt[i].sat));
`else
      chk($sformatf("conv_%0d", i), 64'(word0_cap[i*Q +: Q]), 64'(vt[i].trunc));
`endif
    end
    decode_exit();

    // Frame B: full rate, beat k carries k mod 31 in every lane.
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < B; i++) frame[k][i*IN_Q +: IN_Q] = 8'(k % 31);
    strobe_t.delete();
    load_frame(NB, 0);
    finish_frame();
    chk("strobe_count", 64'(strobe_t.size()), 64'(WORDS));
    for (int i = 1; i < strobe_t.size(); i++)
      chk($sformatf("strobe_gap_%0d", i), 64'(strobe_t[i] - strobe_t[i-1]), 64'(BEATS));
    decode_exit();

    // dec_done while idle must be ignored.
    @(negedge clk);
    dec_done = 1'b1;
    @(negedge clk);
    dec_done = 1'b0;
    chk("idle_done_state", 64'(state_dbg), 64'd0);
    chk("idle_done_channel", 64'(channel), 64'd0);

    // Frame C: ramp LLR[j] = j mod 32 with random stalls.
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < B; i++)
        frame[k][i*IN_Q +: IN_Q] = 8'(((k % BEATS) * B + i) % 32);
    load_frame(NB, 5);
    finish_frame();
    decode_exit();

    // Frame D: reset after 19 beats, then a clean frame.
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < B; i++)
        frame[k][i*IN_Q +: IN_Q] = 8'($urandom_range(0, 255));
    load_frame(19, 0);
    @(negedge clk);
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    check_reset_values("midreset");
    chk("midreset_words_left", 64'(exp_q.size()), 64'd0);
    rst = 1'b0;
    for (int k = 0; k < NB; k++)
      for (int i = 0; i < B; i++)
        frame[k][i*IN_Q +: IN_Q] = 8'(((k % BEATS) * B + i) % 32);
    load_frame(NB, 0);
    finish_frame();
    decode_exit();

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
